// File: rtl/stack_up_mgr_intf_if.sv
// Flit channel used on both sides of the upstream stack-bus interface stage.
// The master drives the flit and valid; the slave answers with ready.
interface stack_up_mgr_intf_if #(
  parameter int DATA_W = 64,
  parameter int OOB_W  = 32,
  parameter int TYPE_W = 2
);
  logic              valid;
  logic [1:0]        cntl;
  logic              ready;
  logic [TYPE_W-1:0] typ;
  logic [DATA_W-1:0] data;
  logic [OOB_W-1:0]  oob_data;

  modport master (output valid, cntl, typ, data, oob_data, input ready);
  modport slave  (input valid, cntl, typ, data, oob_data, output ready);
endinterface

// File: rtl/stack_up_mgr_intf.sv
// Per-manager upstream stack-bus stage: checks message framing on the manager
// side, buffers flits, and releases only whole messages toward the arbiter.
module stack_up_mgr_intf #(
  parameter int DATA_W = 64,
  parameter int OOB_W  = 32,
  parameter int TYPE_W = 2,
  parameter int DEPTH  = 8
) (
  input  logic                clk,
  input  logic                reset_poweron,
  stack_up_mgr_intf_if.slave  mgr_stu_i,
  stack_up_mgr_intf_if.master stu_stk_o,
  output logic                stu__sys__protErr,
  output logic [15:0]         stu__sys__msgCount
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  localparam logic [1:0] CNTL_MOM     = 2'b00;
  localparam logic [1:0] CNTL_SOM     = 2'b01;
  localparam logic [1:0] CNTL_EOM     = 2'b10;
  localparam logic [1:0] CNTL_SOM_EOM = 2'b11;

  typedef struct packed {
    logic [1:0]        cntl;
    logic [TYPE_W-1:0] typ;
    logic [DATA_W-1:0] data;
    logic [OOB_W-1:0]  oob;
  } flit_t;

  typedef enum logic {IN_IDLE = 1'b0, IN_MSG = 1'b1} in_state_e;
  typedef enum logic {OUT_IDLE = 1'b0, OUT_MSG = 1'b1} out_state_e;

  in_state_e     in_state_q, in_state_d;
  out_state_e    out_state_q, out_state_d;
  flit_t         mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] occ_q, occ_d;
  // vis_q trails occ_q by one write so a flit surfaces one edge after storage
  logic [CW-1:0] vis_q, vis_d;
  logic [CW-1:0] eom_pend_q, eom_pend_d;
  logic          wr_vld_q, wr_eom_q;
  logic          init_q;
  logic          prot_err_q, prot_err_d;
  logic [15:0]   msg_cnt_q, msg_cnt_d;

  logic  accept_s, legal_s, wr_en_s, rd_en_s, sent_eom_s;
  logic  ready_s, full_s, out_valid_s;
  flit_t wr_flit_s, head_s;

  assign full_s    = (occ_q == DEPTH_C);
  assign ready_s   = init_q & (occ_q < DEPTH_C);
  assign accept_s  = mgr_stu_i.valid & ready_s;
  assign wr_en_s   = accept_s & legal_s;
  assign wr_flit_s = '{cntl: mgr_stu_i.cntl, typ: mgr_stu_i.typ,
                       data: mgr_stu_i.data, oob: mgr_stu_i.oob_data};
  assign head_s    = mem_q[rd_ptr_q];
  assign rd_en_s   = out_valid_s & stu_stk_o.ready;
  // EOM and SOM_EOM share cntl[1]=1
  assign sent_eom_s = rd_en_s & head_s.cntl[1];

  assign mgr_stu_i.ready    = ready_s;
  assign stu__sys__protErr  = prot_err_q;
  assign stu__sys__msgCount = msg_cnt_q;

  // Input framing FSM: decides legality of each accepted flit
  always_comb begin
    in_state_d = in_state_q;
    legal_s    = 1'b0;
    case (in_state_q)
      IN_IDLE: begin
        legal_s = (mgr_stu_i.cntl == CNTL_SOM) || (mgr_stu_i.cntl == CNTL_SOM_EOM);
        if (accept_s && (mgr_stu_i.cntl == CNTL_SOM)) begin
          in_state_d = IN_MSG;
        end else begin
          in_state_d = in_state_q;
        end
      end
      IN_MSG: begin
        legal_s = (mgr_stu_i.cntl == CNTL_MOM) || (mgr_stu_i.cntl == CNTL_EOM);
        if (accept_s && (mgr_stu_i.cntl == CNTL_EOM)) begin
          in_state_d = IN_IDLE;
        end else begin
          in_state_d = in_state_q;
        end
      end
      default: begin
        in_state_d = IN_IDLE;
        legal_s    = 1'b0;
      end
    endcase
  end

  // Output FSM: a message head waits for a complete message (or a full FIFO)
  always_comb begin
    out_state_d = out_state_q;
    out_valid_s = 1'b0;
    case (out_state_q)
      OUT_IDLE: begin
        if ((vis_q != ZERO_C) && ((eom_pend_q != ZERO_C) || full_s)) begin
          out_valid_s = 1'b1;
        end else begin
          out_valid_s = 1'b0;
        end
        if (out_valid_s && stu_stk_o.ready && (head_s.cntl == CNTL_SOM)) begin
          out_state_d = OUT_MSG;
        end else begin
          out_state_d = out_state_q;
        end
      end
      OUT_MSG: begin
        if (vis_q != ZERO_C) begin
          out_valid_s = 1'b1;
        end else begin
          out_valid_s = 1'b0;
        end
        if (out_valid_s && stu_stk_o.ready && (head_s.cntl == CNTL_EOM)) begin
          out_state_d = OUT_IDLE;
        end else begin
          out_state_d = out_state_q;
        end
      end
      default: begin
        out_state_d = OUT_IDLE;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // Arbiter-facing fields: head flit while valid, zero otherwise
  always_comb begin
    stu_stk_o.valid = out_valid_s;
    if (out_valid_s) begin
      stu_stk_o.cntl     = head_s.cntl;
      stu_stk_o.typ      = head_s.typ;
      stu_stk_o.data     = head_s.data;
      stu_stk_o.oob_data = head_s.oob;
    end else begin
      stu_stk_o.cntl     = 2'b00;
      stu_stk_o.typ      = {TYPE_W{1'b0}};
      stu_stk_o.data     = {DATA_W{1'b0}};
      stu_stk_o.oob_data = {OOB_W{1'b0}};
    end
  end

  // Pointer, occupancy and message-accounting next-state
  always_comb begin
    wr_ptr_d   = wr_en_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d   = rd_en_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    prot_err_d = prot_err_q | (accept_s & ~legal_s);
    msg_cnt_d  = sent_eom_s ? (msg_cnt_q + 16'd1) : msg_cnt_q;
    case ({wr_en_s, rd_en_s})
      2'b10:   occ_d = occ_q + ONE_C;
      2'b01:   occ_d = occ_q - ONE_C;
      default: occ_d = occ_q;
    endcase
    case ({wr_vld_q, rd_en_s})
      2'b10:   vis_d = vis_q + ONE_C;
      2'b01:   vis_d = vis_q - ONE_C;
      default: vis_d = vis_q;
    endcase
    case ({wr_eom_q, sent_eom_s})
      2'b10:   eom_pend_d = eom_pend_q + ONE_C;
      2'b01:   eom_pend_d = eom_pend_q - ONE_C;
      default: eom_pend_d = eom_pend_q;
    endcase
  end

  // Flit storage; only legal accepted flits are written
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_s) begin
      mem_q[wr_ptr_q] <= wr_flit_s;
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      in_state_q  <= IN_IDLE;
      out_state_q <= OUT_IDLE;
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      occ_q       <= ZERO_C;
      vis_q       <= ZERO_C;
      eom_pend_q  <= ZERO_C;
      wr_vld_q    <= 1'b0;
      wr_eom_q    <= 1'b0;
      init_q      <= 1'b0;
      prot_err_q  <= 1'b0;
      msg_cnt_q   <= 16'd0;
    end else begin
      in_state_q  <= in_state_d;
      out_state_q <= out_state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      vis_q       <= vis_d;
      eom_pend_q  <= eom_pend_d;
      wr_vld_q    <= wr_en_s;
      wr_eom_q    <= wr_en_s & mgr_stu_i.cntl[1];
      init_q      <= 1'b1;
      prot_err_q  <= prot_err_d;
      msg_cnt_q   <= msg_cnt_d;
    end
  end

endmodule

// File: tb/tb_stack_up_mgr_intf.sv
// Directed bench for stack_up_mgr_intf: framing table, latency, whole-message
// gating, long messages, random backpressure and mid-message reset.
module tb_stack_up_mgr_intf;

  typedef struct packed {
    logic [1:0]  cntl;
    logic [1:0]  typ;
    logic [63:0] data;
    logic [31:0] oob;
  } flit_t;

  typedef struct {
    logic [1:0]  cntl;
    logic [63:0] data;
    bit          keep;
    bit          perr;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic        prot_err;
  logic [15:0] msg_count;

  stack_up_mgr_intf_if #(.DATA_W(64), .OOB_W(32), .TYPE_W(2)) mgr_if ();
  stack_up_mgr_intf_if #(.DATA_W(64), .OOB_W(32), .TYPE_W(2)) stk_if ();

  stack_up_mgr_intf #(.DATA_W(64), .OOB_W(32), .TYPE_W(2), .DEPTH(8)) dut (
    .clk                (clk),
    .reset_poweron      (rst_n),
    .mgr_stu_i          (mgr_if),
    .stu_stk_o          (stk_if),
    .stu__sys__protErr  (prot_err),
    .stu__sys__msgCount (msg_count)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad = 0;
  bit    rand_bp = 1'b0;
  bit    prev_stall = 1'b0;
  flit_t snap;
  flit_t exp_q [$];
  vec_t  vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard/stability monitor on pre-edge values, then advance one cycle
  task automatic tick();
    flit_t cur, e;
    cur = '{cntl: stk_if.cntl, typ: stk_if.typ, data: stk_if.data, oob: stk_if.oob_data};
    if (rst_n) begin
      if (prev_stall) begin
        chk("stall_valid", {63'd0, stk_if.valid}, 64'd1);
        chk("stall_data", cur.data, snap.data);
        chk("stall_ctl", {28'd0, cur.cntl, cur.typ, cur.oob}, {28'd0, snap.cntl, snap.typ, snap.oob});
      end
      if (stk_if.valid && stk_if.ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_flit: got data %0h expected none", cur.data);
        end else begin
          e = exp_q.pop_front();
          chk("out_cntl", {62'd0, cur.cntl}, {62'd0, e.cntl});
          chk("out_data", cur.data, e.data);
          chk("out_side", {30'd0, cur.typ, cur.oob}, {30'd0, e.typ, e.oob});
        end
      end
      prev_stall = stk_if.valid && !stk_if.ready;
      snap = cur;
    end else begin
      prev_stall = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    if (rand_bp) stk_if.ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [1:0] c, input logic [63:0] d, input bit keep);
    bit done;
    flit_t f;
    done = 1'b0;
    f = '{cntl: c, typ: d[1:0] ^ 2'b10, data: d, oob: d[31:0] ^ 32'hDEADBEEF};
    mgr_if.valid = 1'b1;
    mgr_if.cntl = f.cntl;
    mgr_if.typ = f.typ;
    mgr_if.data = f.data;
    mgr_if.oob_data = f.oob;
    for (int n = 0; n < 300 && !done; n++) begin
      done = mgr_if.ready;
      tick();
    end
    mgr_if.valid = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout: ready never high for data %0h", d);
    end else if (keep) begin
      exp_q.push_back(f);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 400 && (exp_q.size() != 0 || stk_if.valid); n++) tick();
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0] c;
    int len;
    mgr_if.valid = 1'b0;
    mgr_if.cntl = 2'b00;
    mgr_if.typ = 2'b00;
    mgr_if.data = 64'd0;
    mgr_if.oob_data = 32'd0;
    stk_if.ready = 1'b0;

    vecs[0]  = '{2'b11, 64'h10, 1'b1, 1'b0};
    vecs[1]  = '{2'b01, 64'h11, 1'b1, 1'b0};
    vecs[2]  = '{2'b10, 64'h12, 1'b1, 1'b0};
    vecs[3]  = '{2'b00, 64'h13, 1'b0, 1'b1};
    vecs[4]  = '{2'b11, 64'h14, 1'b1, 1'b1};
    vecs[5]  = '{2'b10, 64'h15, 1'b0, 1'b1};
    vecs[6]  = '{2'b01, 64'h16, 1'b1, 1'b1};
    vecs[7]  = '{2'b01, 64'h17, 1'b0, 1'b1};
    vecs[8]  = '{2'b11, 64'h18, 1'b0, 1'b1};
    vecs[9]  = '{2'b00, 64'h19, 1'b1, 1'b1};
    vecs[10] = '{2'b10, 64'h1A, 1'b1, 1'b1};
    vecs[11] = '{2'b11, 64'h1B, 1'b1, 1'b1};

    // Reset values
    tick();
    tick();
    chk("rst_ready", {63'd0, mgr_if.ready}, 64'd0);
    chk("rst_valid", {63'd0, stk_if.valid}, 64'd0);
    chk("rst_data", stk_if.data, 64'd0);
    chk("rst_perr", {63'd0, prot_err}, 64'd0);
    chk("rst_msgcnt", {48'd0, msg_count}, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", {63'd0, mgr_if.ready}, 64'd0);
    tick();
    chk("ready_after_edge", {63'd0, mgr_if.ready}, 64'd1);

    // Single SOM_EOM latency
    stk_if.ready = 1'b1;
    send(2'b11, 64'h1, 1'b1);
    chk("t1_valid_c1", {63'd0, stk_if.valid}, 64'd0);
    tick();
    chk("t1_valid_c2", {63'd0, stk_if.valid}, 64'd1);
    chk("t1_cntl", {62'd0, stk_if.cntl}, 64'd3);
    chk("t1_data", stk_if.data, 64'h1);
    tick();
    chk("t1_valid_c3", {63'd0, stk_if.valid}, 64'd0);
    chk("t1_msgcnt", {48'd0, msg_count}, 64'd1);

    // 4-flit message held back until its EOM is stored
    stk_if.ready = 1'b0;
    send(2'b01, 64'hA0, 1'b1);
    send(2'b00, 64'hA1, 1'b1);
    send(2'b00, 64'hA2, 1'b1);
    tick();
    tick();
    tick();
    chk("t2_no_early", {63'd0, stk_if.valid}, 64'd0);
    send(2'b10, 64'hA3, 1'b1);
    chk("t2_eom_c1", {63'd0, stk_if.valid}, 64'd0);
    tick();
    chk("t2_head_valid", {63'd0, stk_if.valid}, 64'd1);
    chk("t2_head_cntl", {62'd0, stk_if.cntl}, 64'd1);
    stk_if.ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t2_burst_valid", {63'd0, stk_if.valid}, 64'd1);
      tick();
    end
    chk("t2_after_valid", {63'd0, stk_if.valid}, 64'd0);
    chk("t2_msgcnt", {48'd0, msg_count}, 64'd2);
    drain();

    // 12-flit message longer than the FIFO
    for (int i = 0; i < 12; i++) begin
      c = (i == 0) ? 2'b01 : ((i == 11) ? 2'b10 : 2'b00);
      send(c, 64'hB00 + 64'(i), 1'b1);
      if (i < 7) chk("t3_wait_full", {63'd0, stk_if.valid}, 64'd0);
      if (i == 7) chk("t3_start_full", {63'd0, stk_if.valid}, 64'd1);
    end
    drain();
    chk("t3_perr", {63'd0, prot_err}, 64'd0);
    chk("t3_msgcnt", {48'd0, msg_count}, 64'd3);

    // Framing table
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].cntl, vecs[i].data, vecs[i].keep);
      chk($sformatf("vec%0d_perr", i), {63'd0, prot_err}, {63'd0, vecs[i].perr});
    end
    drain();
    chk("tbl_msgcnt", {48'd0, msg_count}, 64'd8);

    // Random backpressure over 100 messages
    rand_bp = 1'b1;
    for (int m = 0; m < 100; m++) begin
      len = $urandom_range(1, 10);
      for (int f = 0; f < len; f++) begin
        c = (len == 1) ? 2'b11 : ((f == 0) ? 2'b01 : ((f == len - 1) ? 2'b10 : 2'b00));
        send(c, {16'(m), 8'(f), 8'h00, 32'($urandom())}, 1'b1);
      end
    end
    drain();
    rand_bp = 1'b0;
    chk("rnd_msgcnt", {48'd0, msg_count}, 64'd108);
    chk("rnd_perr_sticky", {63'd0, prot_err}, 64'd1);

    // Reset with a complete message and a partial one buffered
    stk_if.ready = 1'b0;
    send(2'b11, 64'h55, 1'b0);
    send(2'b01, 64'h60, 1'b0);
    for (int i = 1; i < 5; i++) send(2'b00, 64'h60 + 64'(i), 1'b0);
    tick();
    tick();
    chk("pre_rst_valid", {63'd0, stk_if.valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {63'd0, stk_if.valid}, 64'd0);
    chk("arst_ready", {63'd0, mgr_if.ready}, 64'd0);
    chk("arst_cntl", {62'd0, stk_if.cntl}, 64'd0);
    chk("arst_data", stk_if.data, 64'd0);
    chk("arst_perr", {63'd0, prot_err}, 64'd0);
    chk("arst_msgcnt", {48'd0, msg_count}, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    stk_if.ready = 1'b1;
    tick();
    send(2'b11, 64'h77, 1'b1);
    drain();
    for (int i = 0; i < 10; i++) tick();
    chk("post_rst_msgcnt", {48'd0, msg_count}, 64'd1);
    chk("post_rst_idle", {63'd0, stk_if.valid}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stack_up_mgr_intf.md
Name: stack_up_mgr_intf

Overview:
Per-manager upstream stack-bus interface stage. It sits directly downstream of the manager's mgr__stu__* port and upstream of the shared stack-bus upstream arbiter.
- Accepts flits from the manager under valid/ready and checks message framing.
- Buffers flits in a FIFO and forwards whole messages contiguously toward the arbiter, so the arbiter never sees a partial message stall mid-grant.

Parameters:
DATA_W, 64, width of data field (STACK_UP_INTF_DATA_RANGE)
OOB_W, 32, width of out-of-band field (STACK_UP_INTF_OOB_DATA_RANGE)
TYPE_W, 2, width of type field (STACK_UP_INTF_TYPE_RANGE)
DEPTH, 8, FIFO entries (power of 2, >=4)

Ports:
clk  in  1  clock
reset_poweron  in  1  asynchronous active-low reset
mgr__stu__valid  in  1  manager flit valid
mgr__stu__cntl  in  2  framing: 2'b01 SOM, 2'b00 MOM, 2'b10 EOM, 2'b11 SOM_EOM
stu__mgr__ready  out  1  flit accepted when valid&ready
mgr__stu__tymgr  in  TYPE_W  control/data, vector/scalar
mgr__stu__data  in  DATA_W  payload
mgr__stu__oob_data  in  OOB_W  out-of-band payload
stu__stk__valid  out  1  flit to stack-bus arbiter valid
stu__stk__cntl  out  2  framing, same encoding
stk__stu__ready  in  1  arbiter accepts when valid&ready
stu__stk__type  out  TYPE_W  forwarded type
stu__stk__data  out  DATA_W  forwarded payload
stu__stk__oob_data  out  OOB_W  forwarded oob
stu__sys__protErr  out  1  sticky framing-violation flag
stu__sys__msgCount  out  16  count of messages fully sent upstream, wraps at 0xFFFF->0

Behaviour:
- Reset (reset_poweron=0, async): FIFO empty, all counters 0, input FSM IN_IDLE, output FSM OUT_IDLE. stu__mgr__ready=0 while in reset, 1 from the first clk edge after release. stu__stk__valid=0, cntl/type/data/oob=0, protErr=0, msgCount=0.
- Reset asserted mid-message discards all buffered flits. There is no partial flush.
- stu__mgr__ready = (occupancy < DEPTH). It is derived from registered occupancy only and has no combinational path from stk__stu__ready.
- Input FSM, states IN_IDLE and IN_MSG. Each accepted flit is checked:
  - IN_IDLE + SOM -> IN_MSG, flit written.
  - IN_IDLE + SOM_EOM -> stay, flit written.
  - IN_MSG + MOM -> stay, flit written.
  - IN_MSG + EOM -> IN_IDLE, flit written.
  - Violations: MOM/EOM in IN_IDLE, or SOM/SOM_EOM in IN_MSG. The flit is accepted (ready honoured) but not written, protErr is set (sticky until reset), and the state does not change.
- eomPending counter (0..DEPTH):
  - +1 when an EOM or SOM_EOM flit is written.
  - -1 when an EOM or SOM_EOM flit is sent.
  - Simultaneous +1 and -1 leaves it unchanged.
- Output FSM, states OUT_IDLE and OUT_MSG.
  - A message may start (head flit presented) only when eomPending>0 or occupancy==DEPTH. The full case prevents deadlock on messages longer than DEPTH.
  - Once the head SOM is sent -> OUT_MSG. stu__stk__valid then equals FIFO-not-empty until the EOM is sent -> OUT_IDLE. A SOM_EOM is sent from OUT_IDLE and the FSM stays there.
- Output fields are driven from the FIFO head; a registered output stage is not required.
  - Write-to-visible latency: a flit written at edge N can appear on stu__stk__valid after edge N+1 at the earliest.
  - With the gating condition met, there is no bubble in back-to-back flow. Sustained throughput is 1 flit/clk when stk__stu__ready=1 and input is continuous.
- Payload stability: while stu__stk__valid=1 and stk__stu__ready=0, all stu__stk__* outputs hold stable.
- Simultaneous write and read when full: the write is not possible because ready=0 that cycle. When empty, a read cannot occur. No bypass path exists.
- Pointers are log2(DEPTH) bits and wrap naturally. Occupancy is log2(DEPTH)+1 bits.
- msgCount increments on each sent EOM or SOM_EOM flit.

Test Plan:
- Single SOM_EOM flit, data=0x1, stk ready=1 -> stu__stk__valid high exactly 1 cycle, 2 cycles after acceptance; cntl=2'b11; data=0x1; msgCount=1.
- 4-flit message SOM,MOM,MOM,EOM, ready held 0 until all four are accepted, then 1 -> no output before the EOM is written; then 4 consecutive valid cycles in order; msgCount=1.
- 12-flit message with DEPTH=8, stk ready=1 -> forwarding starts when occupancy hits 8; the whole message is delivered in order with no deadlock; protErr=0.
- MOM sent in IN_IDLE, then a valid SOM_EOM -> MOM dropped; protErr=1 and stays 1; SOM_EOM delivered normally.
- Random stk__stu__ready backpressure (50%) over 100 messages of lengths 1..10 -> output sequence equals input sequence; payload stable while stalled; msgCount=100.
- Reset asserted while 5 flits are buffered mid-message -> all outputs return to reset values asynchronously; after release, a new SOM_EOM is delivered with no stale flits.
